// File: rtl/ipm_fifo_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO family.
// Read-mode selectors, depth calculation and the default almost-full threshold.
package ipm_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Default almost-full sits two words below full.
    function automatic int default_almost_full(input int addr_width);
        return fifo_depth(addr_width) - 2;
    endfunction

endpackage

// File: rtl/ipm_distributed_fifo_ram.sv
// Distributed storage array: synchronous write, asynchronous read, no reset.
module ipm_distributed_fifo_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wr_clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    (* syn_ramstyle = "select_ram" *)
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge wr_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ipm_distributed_sync_fifo.sv
// Single-clock FIFO on distributed storage with count, registered flags,
// overflow/underflow pulses and standard or first-word-fall-through read.
module ipm_distributed_sync_fifo
    import ipm_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int FWFT             = FWFT_OFF,
    parameter int ALMOST_FULL_NUM  = default_almost_full(ADDR_WIDTH),
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10 || DATA_WIDTH < 1 || DATA_WIDTH > 256 ||
        ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH ||
        ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_cfg_err
        $error("ipm_distributed_sync_fifo: parameter out of legal range");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, afull_q, empty_q, aempty_q;
    logic                  ovf_q, unf_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_q;

    // Accept decisions use only registered flags, so inputs never reach a flag combinationally.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    assign wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    assign rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_acc);
    assign count_d  = count_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            afull_q  <= (count_d >= CNT_AF);
            empty_q  <= (count_d == '0);
            aempty_q <= (count_d <= CNT_AE);
            ovf_q    <= wr_en & full_q;
            unf_q    <= rd_en & empty_q;
        end
    end

    ipm_distributed_fifo_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .wr_clk  (wr_clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_q)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign rd_data = ram_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge wr_clk or posedge asyn_rst) begin
            if (asyn_rst) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= ram_q;
            end
        end

        assign rd_data = rd_data_q;
    end

    assign wr_full      = full_q;
    assign almost_full  = afull_q;
    assign rd_empty     = empty_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_ipm_distributed_sync_fifo.sv
// Bench for ipm_distributed_sync_fifo: standard and FWFT instances share one
// stimulus stream and are compared each cycle against a queue-based model.
`timescale 1ns/1ps
module tb_ipm_distributed_sync_fifo;

    logic       wr_clk = 1'b0;
    logic       asyn_rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;

    logic [7:0] rd_data0, rd_data1;
    logic       wr_full0, almost_full0, rd_empty0, almost_empty0, overflow0, underflow0;
    logic       wr_full1, almost_full1, rd_empty1, almost_empty1, overflow1, underflow1;
    logic [4:0] count0, count1;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: stored words, last standard-mode read, pulse expectations.
    logic [7:0] m_q[$];
    logic [7:0] m_rd = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #10 wr_clk = ~wr_clk;

    ipm_distributed_sync_fifo #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) dut_std (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data0), .wr_full(wr_full0),
        .almost_full(almost_full0), .rd_empty(rd_empty0),
        .almost_empty(almost_empty0), .count(count0),
        .overflow(overflow0), .underflow(underflow0)
    );

    ipm_distributed_sync_fifo #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) dut_fwft (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data1), .wr_full(wr_full1),
        .almost_full(almost_full1), .rd_empty(rd_empty1),
        .almost_empty(almost_empty1), .count(count1),
        .overflow(overflow1), .underflow(underflow1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a FIFO of depth 16 expressed as a queue.
    initial begin
        forever begin
            @(posedge wr_clk or posedge asyn_rst);
            if (asyn_rst) begin
                m_q.delete();
                m_rd  = 8'h00;
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                logic was_full, was_empty;
                was_full  = (m_q.size() == 16);
                was_empty = (m_q.size() == 0);
                m_ovf = wr_en && was_full;
                m_unf = rd_en && was_empty;
                if (rd_en && !was_empty) m_rd = m_q.pop_front();
                if (wr_en && !was_full) m_q.push_back(wr_data);
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        forever begin
            int sz;
            @(negedge wr_clk);
            sz = m_q.size();
            chk("count",        32'(count0),        32'(sz));
            chk("wr_full",      32'(wr_full0),      32'(sz == 16));
            chk("almost_full",  32'(almost_full0),  32'(sz >= 14));
            chk("rd_empty",     32'(rd_empty0),     32'(sz == 0));
            chk("almost_empty", 32'(almost_empty0), 32'(sz <= 2));
            chk("overflow",     32'(overflow0),     32'(m_ovf));
            chk("underflow",    32'(underflow0),    32'(m_unf));
            chk("rd_data_std",  32'(rd_data0),      32'(m_rd));
            chk("fwft_count",   32'(count1),        32'(sz));
            chk("fwft_rd_empty", 32'(rd_empty1),    32'(sz == 0));
            chk("fwft_flags", {28'd0, wr_full1, almost_full1, almost_empty1, overflow1 | underflow1},
                {28'd0, sz == 16, sz >= 14, sz <= 2, m_ovf | m_unf});
            if (sz > 0) chk("rd_data_fwft", 32'(rd_data1), 32'(m_q[0]));
        end
    end

    task automatic drive(input logic we, input logic [7:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge wr_clk);
        #1;
        asyn_rst = 1'b0;
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_empty", {30'd0, rd_empty0, almost_empty0}, 32'd3);
        chk("rst_full",  {30'd0, wr_full0, almost_full0}, 32'd0);
        chk("rst_rd_data", 32'(rd_data0), 32'd0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            if (i == 1)  chk("ae_after2",  32'(almost_empty0), 32'd1);
            if (i == 2)  chk("ae_after3",  32'(almost_empty0), 32'd0);
            if (i == 12) chk("af_after13", 32'(almost_full0),  32'd0);
            if (i == 13) chk("af_after14", 32'(almost_full0),  32'd1);
            if (i == 14) chk("full_after15", 32'(wr_full0),    32'd0);
        end
        chk("fill_count", 32'(count0), 32'd16);
        chk("fill_full",  32'(wr_full0), 32'd1);

        drive(1'b1, 8'hFF, 1'b0);
        chk("ovf_pulse", 32'(overflow0), 32'd1);
        chk("ovf_count", 32'(count0), 32'd16);
        drive(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(overflow0), 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(rd_data0), 32'(i));
        end
        chk("drain_empty", 32'(rd_empty0), 32'd1);

        drive(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", 32'(underflow0), 32'd1);
        chk("unf_hold",  32'(rd_data0), 32'h0F);
        chk("unf_count", 32'(count0), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        chk("unf_clear", 32'(underflow0), 32'd0);

        // Simultaneous requests at full, then at empty.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        chk("full_both_count", 32'(count0), 32'd15);
        chk("full_both_ovf",   32'(overflow0), 32'd1);
        for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h77, 1'b1);
        chk("empty_both_count", 32'(count0), 32'd1);
        chk("empty_both_unf",   32'(underflow0), 32'd1);

        // Steady state at five words across pointer wrap.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom), 1'b1);
            chk("steady_count", 32'(count0), 32'd5);
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1);

        // Fall-through of a single word.
        drive(1'b1, 8'hA5, 1'b0);
        chk("fwft_nonempty", 32'(rd_empty1), 32'd0);
        chk("fwft_head",     32'(rd_data1), 32'hA5);
        drive(1'b0, 8'h00, 1'b1);
        chk("fwft_popped",   32'(rd_empty1), 32'd1);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h90 + i), 1'b0);
        chk("pre_rst_count", 32'(count0), 32'd9);
        #2 asyn_rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count0), 32'd0);
        chk("mid_rst_empty", {30'd0, rd_empty0, almost_empty0}, 32'd3);
        chk("mid_rst_full",  {30'd0, wr_full0, almost_full0}, 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data0), 32'd0);
        #1 asyn_rst = 1'b0;
        @(posedge wr_clk);
        #1;
        drive(1'b1, 8'h3C, 1'b0);
        chk("post_rst_fwft", 32'(rd_data1), 32'h3C);
        drive(1'b0, 8'h00, 1'b1);
        chk("post_rst_std",  32'(rd_data0), 32'h3C);

        // Randomized traffic at write-heavy, read-heavy and balanced mixes.
        for (int seg = 0; seg < 3; seg++) begin
            int wb, rb;
            wb = (seg == 0) ? 75 : (seg == 1) ? 30 : 50;
            rb = (seg == 0) ? 30 : (seg == 1) ? 75 : 50;
            for (int i = 0; i < 150; i++) begin
                drive($urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < rb);
            end
        end

        @(negedge wr_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ipm_distributed_sync_fifo.md
Name: ipm_distributed_sync_fifo

Overview:
- Single-clock FIFO built on distributed (select_ram-style) storage; successor to the plain distributed SDPRAM primitive used inside our FIFO IP.
- Adds pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, overflow/underflow pulses, and a selectable read mode: standard (registered) or first-word-fall-through (FWFT).
- Used as a shallow rate/skid buffer between conv3x3 pipeline stages.

Parameters:
- ADDR_WIDTH, 4, log2 depth; depth = 2**ADDR_WIDTH; legal range 4-10.
- DATA_WIDTH, 8, word width; legal range 1-256.
- FWFT, 0, read mode. 0 = standard (rd_data registered, 1-cycle latency). 1 = first-word-fall-through.
- ALMOST_FULL_NUM, 2**ADDR_WIDTH-2, almost_full asserts when count >= this value; legal range 1..depth.
- ALMOST_EMPTY_NUM, 2, almost_empty asserts when count <= this value; legal range 0..depth-1.

Ports:
- wr_clk  in  1  sole clock; all state updates on its rising edge.
- asyn_rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request (standard mode) / pop acknowledge (FWFT).
- rd_data  out  DATA_WIDTH  read word.
- wr_full  out  1  FIFO holds depth words.
- almost_full  out  1  count >= ALMOST_FULL_NUM.
- rd_empty  out  1  FIFO holds 0 words.
- almost_empty  out  1  count <= ALMOST_EMPTY_NUM.
- count  out  ADDR_WIDTH+1  occupancy, 0..depth.
- overflow  out  1  one-cycle pulse: write request refused.
- underflow  out  1  one-cycle pulse: read request refused.

Behaviour:
- Reset (asyn_rst=1, asynchronous, takes effect immediately):
  - wr_ptr=rd_ptr=0, count=0.
  - rd_empty=1, almost_empty=1, wr_full=0, almost_full=0.
  - overflow=underflow=0; standard-mode rd_data register=0.
  - Memory contents are not cleared. Reset mid-operation discards all stored words.
- Pointers: ADDR_WIDTH bits, wrap modulo depth. Occupancy is tracked by the count register, not pointer compare.
- Accept rules, evaluated on the registered flags:
  - wr_acc = wr_en & ~wr_full.
  - rd_acc = rd_en & ~rd_empty.
- Simultaneous events:
  - Both accepted: count unchanged, both pointers advance.
  - Full with wr_en & rd_en: read accepted, write refused, overflow pulses. count becomes depth-1.
  - Empty with wr_en & rd_en: write accepted, read refused, underflow pulses. count becomes 1.
- count_next = count + wr_acc - rd_acc.
  - All flags are registered and computed from count_next, so they change on the same edge as count.
  - No combinational path from inputs to flags.
- Write: mem[wr_ptr] <= wr_data on wr_acc. A write at edge N is readable from cycle N+1: rd_empty falls after edge N.
- Storage read is asynchronous: q = mem[rd_ptr].
- FWFT=0 (standard):
  - On rd_acc, rd_data <= q at the same edge, so data is valid in the cycle after the request edge.
  - rd_data holds its value otherwise, including on underflow.
- FWFT=1:
  - rd_data = q combinationally. Whenever rd_empty=0, it shows the head word.
  - rd_acc pops the head; the next word appears after the edge.
  - rd_data is don't-care while empty.
- overflow/underflow: registered, high for exactly the cycle after the offending edge; they do not stick.
- Threshold parameters outside their legal range are a configuration error; flag behaviour is then undefined (elaboration assertion in simulation).

Decomposition:
- Shared package ipm_fifo_pkg:
  - Read-mode constants FWFT_OFF=0, FWFT_ON=1.
  - Function fifo_depth(ADDR_WIDTH).
  - Default-threshold helper.
- Sub-module ipm_distributed_fifo_ram:
  - Write-synchronous, read-asynchronous array, DATA_WIDTH x 2**ADDR_WIDTH.
  - select_ram synthesis attribute; no reset.
  - Top level holds pointers, count, flags and read register.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8, AF=14, AE=2 unless noted):
- Fill: 16 writes 0x00..0x0F, no reads -> count=16, wr_full=1 after 16th edge; almost_full rises after 14th edge; almost_empty falls after 3rd edge.
- Overflow: 17th write while full -> overflow high 1 cycle, count stays 16, contents unchanged. Then 16 reads (FWFT=0) -> rd_data 0x00..0x0F, each one cycle after its request edge; rd_empty=1 at the end.
- Underflow: rd_en on empty FIFO -> underflow pulse 1 cycle, rd_data holds last value 0x0F, count=0.
- Simultaneous at boundaries:
  - Full + wr_en & rd_en -> count 16->15, overflow=1.
  - Empty + wr_en & rd_en -> count 0->1, underflow=1.
  - Steady state at count=5 with both asserted for 20 cycles -> count stays 5, data order preserved across pointer wrap.
- FWFT=1: write 0xA5 at edge N -> rd_empty=0 and rd_data=0xA5 in cycle N+1 with no rd_en; rd_en pops it and rd_empty=1 after the next edge.
- Async reset mid-stream: with count=9, pulse asyn_rst between clock edges -> count=0, rd_empty=1, flags reset immediately. A subsequent write of 0x3C reads back 0x3C, not stale data.
